// File: rtl/jzjpcc_memory.sv
// jzjpcc memory stage: data-bus access with ready handshake, load formatting, writeback register.
// Optional bus timeout is enabled by defining JZJPCC_MEM_TIMEOUT_EN (TIMEOUT_CYCLES sets the WAIT limit).
module jzjpcc_memory #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid,
    input  logic [31:0] aluResult,
    input  logic [29:0] memAddress,
    input  logic        memoryWriteEnable,
    input  logic [31:0] memDataToWrite,
    input  logic [3:0]  memByteMask,
    input  logic [2:0]  funct3,
    input  logic        rdSource,
    input  logic [4:0]  rdAddr,
    input  logic        rdWriteEnable,
    output logic        stall,
    output logic        busReq,
    output logic        busWrite,
    output logic [29:0] busAddr,
    output logic [31:0] busWData,
    output logic [3:0]  busByteMask,
    input  logic        busReady,
    input  logic [31:0] busRData,
    output logic [4:0]  rdAddr_wb,
    output logic        rdWriteEnable_wb,
    output logic [31:0] rdData_wb,
    output logic        busError
);
    // state | meaning
    // IDLE  | no access outstanding, or an access completing with zero wait
    // WAIT  | access issued, waiting for busReady (or timeout)

    logic        access;
    logic        timeout_hit;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    assign access      = valid & (memoryWriteEnable | rdSource);
    assign busReq      = access & reset;
    assign busWrite    = memoryWriteEnable;
    assign busAddr     = memAddress;
    assign busWData    = memDataToWrite;
    assign busByteMask = memoryWriteEnable ? memByteMask : 4'b0000;
    assign stall       = access & ~busReady & ~timeout_hit;

`ifdef JZJPCC_MEM_TIMEOUT_EN
    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] wait_count;

    assign timeout_hit = (state == WAIT) & (wait_count == TIMEOUT_LAST) & ~busReady;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            wait_count <= '0;
            busError   <= 1'b0;
        end else begin
            busError <= timeout_hit;
            case (state)
                IDLE: begin
                    wait_count <= '0;
                    if (access && !busReady)
                        state <= WAIT;
                end
                WAIT: begin
                    if (busReady || timeout_hit) begin
                        state      <= IDLE;
                        wait_count <= '0;
                    end else begin
                        wait_count <= wait_count + 16'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    wait_count <= '0;
                end
            endcase
        end
    end
`else
    // Without a timeout, WAIT is exactly "access pending and not ready", which stall already encodes.
    assign timeout_hit = 1'b0;
    assign busError    = 1'b0;
`endif

    always_comb begin
        load_byte = busRData[{aluResult[1:0], 3'b000} +: 8];
        load_half = aluResult[1] ? busRData[31:16] : busRData[15:0];
        case (funct3)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_data = {24'h0, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b101:  load_data = {16'h0, load_half};
            3'b010:  load_data = busRData;
            default: load_data = 32'h0;
        endcase
        // An abandoned load returns zero rather than whatever the bus happens to present.
        if (timeout_hit)
            load_data = 32'h0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rdAddr_wb        <= 5'd0;
            rdWriteEnable_wb <= 1'b0;
            rdData_wb        <= 32'h0;
        end else if (stall || !valid) begin
            rdWriteEnable_wb <= 1'b0;
        end else begin
            rdAddr_wb        <= rdAddr;
            rdWriteEnable_wb <= rdWriteEnable;
            rdData_wb        <= rdSource ? load_data : aluResult;
        end
    end
endmodule

// File: tb/tb_jzjpcc_memory.sv
// Directed bench for jzjpcc_memory: per-cycle model comparison plus hand-computed literal checks.
// Timeout scenario runs only when JZJPCC_MEM_TIMEOUT_EN is defined.
module tb_jzjpcc_memory;
    localparam int unsigned TO = 4;
`ifdef JZJPCC_MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] aluResult = '0;
    logic [29:0] memAddress = '0;
    logic        memoryWriteEnable = 1'b0;
    logic [31:0] memDataToWrite = '0;
    logic [3:0]  memByteMask = '0;
    logic [2:0]  funct3 = '0;
    logic        rdSource = 1'b0;
    logic [4:0]  rdAddr = '0;
    logic        rdWriteEnable = 1'b0;
    logic        busReady = 1'b0;
    logic [31:0] busRData = '0;
    logic        stall, busReq, busWrite, rdWriteEnable_wb, busError;
    logic [29:0] busAddr;
    logic [31:0] busWData, rdData_wb;
    logic [3:0]  busByteMask;
    logic [4:0]  rdAddr_wb;

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    logic [4:0]  m_addr = '0;
    logic        m_we = 1'b0;
    logic [31:0] m_data = '0;
    logic        m_err = 1'b0;
    int unsigned streak = 0;

    typedef struct packed {
        logic [31:0] alu;
        logic [2:0]  f3;
        logic [31:0] rdata;
        logic [31:0] exp;
    } ld_t;
    ld_t ld_tab [8];

    always #5 clock = ~clock;

    jzjpcc_memory #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .valid(valid), .aluResult(aluResult),
        .memAddress(memAddress), .memoryWriteEnable(memoryWriteEnable),
        .memDataToWrite(memDataToWrite), .memByteMask(memByteMask), .funct3(funct3),
        .rdSource(rdSource), .rdAddr(rdAddr), .rdWriteEnable(rdWriteEnable),
        .stall(stall), .busReq(busReq), .busWrite(busWrite), .busAddr(busAddr),
        .busWData(busWData), .busByteMask(busByteMask), .busReady(busReady),
        .busRData(busRData), .rdAddr_wb(rdAddr_wb), .rdWriteEnable_wb(rdWriteEnable_wb),
        .rdData_wb(rdData_wb), .busError(busError)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Load result from the architectural rules: shift the addressed lane down, then extend.
    function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
        logic [31:0]        sh;
        logic [31:0]        hs;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        sh = w >> (32'(a) * 8);
        hs = w >> (32'(a[1]) * 16);
        b  = sh[7:0];
        h  = hs[15:0];
        case (f3)
            3'b000:  return 32'(b);
            3'b100:  return {24'h0, sh[7:0]};
            3'b001:  return 32'(h);
            3'b101:  return {16'h0, hs[15:0]};
            3'b010:  return w;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_access();
        return valid && (memoryWriteEnable || rdSource);
    endfunction

    // Timeout fires on the access's cycle whose index (from 0) equals TO, i.e. after TO stalled cycles.
    function automatic bit m_timeout();
        return TO_EN && m_access() && !busReady && (streak == TO);
    endfunction

    always @(posedge clock) begin
        bit to;
        to = m_timeout();
        if (!reset) begin
            m_addr = '0; m_we = 1'b0; m_data = '0; m_err = 1'b0; streak = 0;
        end else begin
            m_err = to;
            if (m_access() && !busReady && !to) begin
                m_we = 1'b0;
                streak++;
            end else begin
                streak = 0;
                if (!valid) m_we = 1'b0;
                else begin
                    m_addr = rdAddr;
                    m_we   = rdWriteEnable;
                    m_data = !rdSource ? aluResult : (to ? 32'h0 : fmt(funct3, aluResult[1:0], busRData));
                end
            end
        end
    end

    always @(negedge clock) begin
        if (mon_on) begin
            chk("stall", 32'(stall), 32'(m_access() && !busReady && !m_timeout()));
            chk("busReq", 32'(busReq), 32'(m_access() && reset));
            chk("busWrite", 32'(busWrite), 32'(memoryWriteEnable));
            chk("busAddr", 32'(busAddr), 32'(aluResult[31:2]));
            chk("busWData", busWData, memDataToWrite);
            chk("busByteMask", 32'(busByteMask), 32'(memoryWriteEnable ? memByteMask : 4'h0));
            chk("rdAddr_wb", 32'(rdAddr_wb), 32'(m_addr));
            chk("rdWriteEnable_wb", 32'(rdWriteEnable_wb), 32'(m_we));
            chk("rdData_wb", rdData_wb, m_data);
            chk("busError", 32'(busError), 32'(m_err));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic st, input logic src, input logic [31:0] alu,
                         input logic [2:0] f3, input logic [4:0] rd, input logic rdwe,
                         input logic [31:0] wd, input logic [3:0] mask);
        valid = v; memoryWriteEnable = st; rdSource = src; aluResult = alu;
        memAddress = alu[31:2]; funct3 = f3; rdAddr = rd; rdWriteEnable = rdwe;
        memDataToWrite = wd; memByteMask = mask;
    endtask

    initial begin
        #60000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        ld_tab[0] = '{32'h0000_1003, 3'b000, 32'h80FF_0000, 32'hFFFF_FF80};
        ld_tab[1] = '{32'h0000_1002, 3'b101, 32'hBEEF_1234, 32'h0000_BEEF};
        ld_tab[2] = '{32'h0000_1002, 3'b001, 32'hBEEF_1234, 32'hFFFF_BEEF};
        ld_tab[3] = '{32'h0000_1003, 3'b001, 32'hBEEF_1234, 32'hFFFF_BEEF};
        ld_tab[4] = '{32'h0000_1000, 3'b010, 32'hBEEF_1234, 32'hBEEF_1234};
        ld_tab[5] = '{32'h0000_1001, 3'b100, 32'h0000_8100, 32'h0000_0081};
        ld_tab[6] = '{32'h0000_1000, 3'b000, 32'h0000_007F, 32'h0000_007F};
        ld_tab[7] = '{32'h0000_1000, 3'b011, 32'hFFFF_FFFF, 32'h0000_0000};

        step();
        step();
        mon_on = 1'b1;
        chk("reset_rdWriteEnable_wb", 32'(rdWriteEnable_wb), 32'd0);
        chk("reset_rdData_wb", rdData_wb, 32'd0);
        chk("reset_rdAddr_wb", 32'(rdAddr_wb), 32'd0);
        chk("reset_busError", 32'(busError), 32'd0);
        drive(1, 0, 1, 32'h0000_1000, 3'b010, 5'd4, 1, 32'h0, 4'h0);
        @(negedge clock);
        chk("busReq_forced_in_reset", 32'(busReq), 32'd0);
        step();

        reset = 1'b1;
        drive(1, 0, 0, 32'h0000_1234, 3'b000, 5'd5, 1, 32'h0, 4'h0);
        @(negedge clock);
        chk("alu_stall", 32'(stall), 32'd0);
        chk("alu_busReq", 32'(busReq), 32'd0);
        step();
        chk("alu_data", rdData_wb, 32'h0000_1234);
        chk("alu_addr", 32'(rdAddr_wb), 32'd5);
        chk("alu_we", 32'(rdWriteEnable_wb), 32'd1);

        busReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 1, ld_tab[i].alu, ld_tab[i].f3, 5'd7, 1, 32'h0, 4'h0);
            busRData = ld_tab[i].rdata;
            @(negedge clock);
            chk("load_stall", 32'(stall), 32'd0);
            step();
            chk("load_data", rdData_wb, ld_tab[i].exp);
            chk("load_we", 32'(rdWriteEnable_wb), 32'd1);
        end

        busReady = 1'b0;
        drive(1, 1, 0, 32'h0000_2000, 3'b010, 5'd0, 0, 32'hDEAD_BEEF, 4'hF);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (stall) n++;
            chk("sw_busReq", 32'(busReq), 32'd1);
            chk("sw_busAddr", 32'(busAddr), 32'h0000_0800);
            chk("sw_busWData", busWData, 32'hDEAD_BEEF);
            chk("sw_mask", 32'(busByteMask), 32'h0000_000F);
            step();
            chk("sw_bubble", 32'(rdWriteEnable_wb), 32'd0);
        end
        chk("sw_stall_cycles", 32'(n), 32'd3);
        busReady = 1'b1;
        @(negedge clock);
        chk("sw_release", 32'(stall), 32'd0);
        step();
        chk("sw_wb_data", rdData_wb, 32'h0000_2000);
        busReady = 1'b0;
        drive(1, 0, 0, 32'h0000_0077, 3'b000, 5'd6, 1, 32'h0, 4'h0);
        @(negedge clock);
        chk("sw_busReq_drop", 32'(busReq), 32'd0);
        step();

        busReady = 1'b1;
        busRData = 32'h1122_3344;
        drive(1, 0, 1, 32'h0000_3000, 3'b010, 5'd8, 1, 32'h0, 4'h0);
        step();
        chk("b2b_first", rdData_wb, 32'h1122_3344);
        busReady = 1'b0;
        busRData = 32'h0000_AB00;
        drive(1, 0, 1, 32'h0000_3001, 3'b100, 5'd9, 1, 32'h0, 4'h0);
        @(negedge clock);
        chk("b2b_stall", 32'(stall), 32'd1);
        step();
        busReady = 1'b1;
        step();
        chk("b2b_second", rdData_wb, 32'h0000_00AB);

        drive(0, 0, 1, 32'h0000_3000, 3'b010, 5'd11, 1, 32'h0, 4'h0);
        @(negedge clock);
        chk("bubble_busReq", 32'(busReq), 32'd0);
        step();
        chk("bubble_we", 32'(rdWriteEnable_wb), 32'd0);

`ifdef JZJPCC_MEM_TIMEOUT_EN
        busReady = 1'b0;
        busRData = 32'hCAFE_F00D;
        drive(1, 0, 1, 32'h0000_4000, 3'b010, 5'd9, 1, 32'h0, 4'h0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (!stall) break;
            n++;
        end
        chk("timeout_stall_cycles", 32'(n), 32'd4);
        step();
        chk("timeout_busError", 32'(busError), 32'd1);
        chk("timeout_data", rdData_wb, 32'h0);
        drive(1, 0, 0, 32'h0000_0055, 3'b000, 5'd3, 1, 32'h0, 4'h0);
        step();
        chk("timeout_pulse_end", 32'(busError), 32'd0);
        chk("timeout_next", rdData_wb, 32'h0000_0055);
`endif

        busReady = 1'b0;
        drive(1, 0, 1, 32'h0000_5000, 3'b010, 5'd10, 1, 32'h0, 4'h0);
        step();
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_wait_busReq", 32'(busReq), 32'd0);
        step();
        chk("rst_wait_data", rdData_wb, 32'h0);
        chk("rst_wait_addr", 32'(rdAddr_wb), 32'd0);
        chk("rst_wait_we", 32'(rdWriteEnable_wb), 32'd0);
        reset = 1'b1;
        valid = 1'b0;
        busReady = 1'b1;
        @(negedge clock);
        chk("rst_late_busReq", 32'(busReq), 32'd0);
        step();
        chk("rst_late_we", 32'(rdWriteEnable_wb), 32'd0);
        step();

        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jzjpcc_memory.md
Name: jzjpcc_memory

Overview:
- Memory stage of the jzjpcc 5-stage pipeline; sits directly downstream of execute and upstream of writeback.
- Consumes execute's registered outputs: ALU result, store data, byte mask, funct3 and rd control.
- Performs the data-bus access with a ready handshake, stalling upstream while the bus is busy.
- Formats load data (byte/half select, sign/zero extension) and registers the result for writeback.

Parameters:
- TIMEOUT_CYCLES, 255: WAIT-state cycles before a bus access is abandoned. Used only with the optional feature; legal range 1..65535.

Ports:
- clock  in  1  pipeline clock
- reset  in  1  synchronous, active-low reset
- valid  in  1  execute output holds a real instruction (0 = bubble)
- aluResult  in  32  ALU result; byte address for loads and stores
- memAddress  in  30  word address [31:2]
- memoryWriteEnable  in  1  store instruction
- memDataToWrite  in  32  store data, pre-shifted into byte lanes
- memByteMask  in  4  store byte-lane enables
- funct3  in  3  load width/sign
- rdSource  in  1  0 = ALU, 1 = memory (load)
- rdAddr  in  5  destination register
- rdWriteEnable  in  1  destination write enable
- stall  out  1  upstream must hold all inputs stable and not advance
- busReq  out  1  bus request
- busWrite  out  1  1 = store, 0 = load
- busAddr  out  30  word address
- busWData  out  32  store data
- busByteMask  out  4  store lanes; 4'b0000 on loads
- busReady  in  1  bus completes the access this cycle
- busRData  in  32  load word; valid when busReady = 1
- rdAddr_wb  out  5  to writeback
- rdWriteEnable_wb  out  1  to writeback
- rdData_wb  out  32  to writeback
- busError  out  1  timeout pulse

Behaviour:
- Access condition: access = valid & (memoryWriteEnable | rdSource).
- Reset (reset = 0 at a clock edge):
  - state goes to IDLE; waitCount goes to 0.
  - All registered outputs go to 0: rdAddr_wb, rdWriteEnable_wb, rdData_wb, busError.
  - busReq is forced 0 during reset.
- FSM states: IDLE and WAIT.
  - busReq = access, driven combinationally in both states.
  - bus outputs are driven combinationally from the inputs.
  - IDLE to WAIT: access & !busReady.
  - WAIT to IDLE: busReady, or timeout.
  - IDLE stays IDLE: access & busReady (zero-wait completion).
- Stall: stall = access & !busReady & !timeoutHit.
  - Upstream holds its inputs while stall = 1, so bus outputs remain stable in WAIT.
- Writeback register, updated every clock edge:
  - Stalled: insert a bubble (rdWriteEnable_wb <= 0).
  - valid = 0: rdWriteEnable_wb <= 0.
  - Otherwise: rdAddr_wb <= rdAddr; rdWriteEnable_wb <= rdWriteEnable; rdData_wb <= (rdSource ? loadData : aluResult).
- Latency:
  - Non-memory instruction: 1 cycle.
  - Memory access: 1 + number of cycles busReady is low.
- Load formatting, taking bytes from busRData (a = aluResult[1:0]):
  - 000 LB: byte a, sign-extended.
  - 100 LBU: byte a, zero-extended.
  - 001 LH: halfword aluResult[1], sign-extended; aluResult[0] ignored.
  - 101 LHU: halfword aluResult[1], zero-extended; aluResult[0] ignored.
  - 010 LW: full word.
  - Any other funct3: 32'h0.
- Stores:
  - rdData_wb <= aluResult.
  - rdWriteEnable passes through (decode drives it 0).
- Back-to-back accesses: the next access may start in the cycle after completion. No idle cycle is required.
- Reset during WAIT: the access is abandoned. busReq is 0 from that edge, and a late busReady is ignored.

Optional Feature:
- Macro: JZJPCC_MEM_TIMEOUT_EN
- Enabled:
  - waitCount increments each WAIT cycle and clears on leaving WAIT.
  - timeoutHit = (state == WAIT) & (waitCount == TIMEOUT_CYCLES - 1) & !busReady.
  - On timeout: the access completes; a load writes rdData_wb = 0; stall is released; busError = 1 for exactly one cycle (registered); FSM returns to IDLE.
- Disabled:
  - timeoutHit = 0; WAIT holds indefinitely.
  - busError is tied 0; no counter logic is present.

Test Plan:
- ALU op: valid = 1, rdSource = 0, aluResult = 32'h1234, rdAddr = 5, rdWriteEnable = 1 -> next cycle rdData_wb = 32'h1234, rdAddr_wb = 5, rdWriteEnable_wb = 1; stall and busReq stay 0.
- LB: aluResult[1:0] = 3, busRData = 32'h80FF_0000, busReady = 1 in the same cycle -> rdData_wb = 32'hFFFF_FF80 next cycle; stall never asserted.
- LHU: aluResult[1:0] = 2, busRData = 32'hBEEF_1234 -> rdData_wb = 32'h0000_BEEF. LH with the same inputs -> rdData_wb = 32'hFFFF_BEEF.
- SW with busReady low for 3 cycles:
  - stall = 1 for 3 cycles; busReq, busAddr, busWData and busByteMask = 4'hF stay stable throughout.
  - rdWriteEnable_wb = 0 during the stall; busReq drops after the busReady cycle.
- Timeout (macro on, TIMEOUT_CYCLES = 4): load with busReady held 0 -> stall = 1 for 4 cycles, then one busError pulse; rdData_wb = 0; the next instruction proceeds.
- Reset mid-WAIT: reset = 0 during the second WAIT cycle -> busReq = 0 on that edge; all _wb outputs 0; state IDLE; a busReady after reset produces no writeback.
